// File: rtl/blackjack_game_fsm.sv
// Blackjack round controller: card draws over req/valid, soft-ace totals,
// round outcome for the display block and deck reload sequencing.
module blackjack_game_fsm #(
   parameter int DEALER_STAND = 17,
   parameter int BJ_TOTAL     = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_deal,
   input  logic       btn_hit,
   input  logic       btn_stand,
   input  logic       card_valid,
   input  logic [3:0] card_rank,
   input  logic       deck_low,
   input  logic       shuffle_done,
   output logic       card_req,
   output logic       shuffle_start,
   output logic [2:0] state,
   output logic [4:0] player_hand,
   output logic [4:0] dealer_hand,
   output logic [1:0] display_state,
   output logic       reset_to_reshuffle
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DEAL   = 3'd1,
      S_PLAYER = 3'd2,
      S_DEALER = 3'd3,
      S_END    = 3'd4,
      S_LOAD   = 3'd5
   } state_t;

   localparam logic [1:0] D_LOSE = 2'd0;
   localparam logic [1:0] D_TIE  = 2'd1;
   localparam logic [1:0] D_WIN  = 2'd2;
   localparam logic [1:0] D_BJ   = 2'd3;

   localparam logic [4:0] L_STAND = 5'(DEALER_STAND);
   localparam logic [4:0] L_BJ    = 5'(BJ_TOTAL);

   state_t     r_state, w_state;
   logic       r_card_req, w_card_req;
   logic       r_shuf, w_shuf;
   logic [4:0] r_ph, w_ph;
   logic [4:0] r_dh, w_dh;
   logic       r_ps, w_ps;
   logic       r_ds, w_ds;
   logic [1:0] r_disp, w_disp;
   logic       r_reshuf, w_reshuf;
   logic [2:0] r_cnt, w_cnt;
   logic       w_acc;
   logic [5:0] w_pc, w_dc;

   // Returns {soft, total}; an ace counts 11 only while that keeps the hand <= 21.
   function automatic logic [5:0] add_card(input logic [4:0] h,
                                           input logic       s,
                                           input logic [3:0] rank);
      logic [5:0] t;
      logic       ns;
      ns = s;
      if (rank == 4'd1) begin
         if ({1'b0, h} + 6'd11 <= {1'b0, L_BJ}) begin
            t  = {1'b0, h} + 6'd11;
            ns = 1'b1;
         end else begin
            t = {1'b0, h} + 6'd1;
         end
      end else if (rank >= 4'd10 || rank == 4'd0) begin
         t = {1'b0, h} + 6'd10;
      end else begin
         t = {1'b0, h} + {2'b00, rank};
      end
      if (t > {1'b0, L_BJ} && ns) begin
         t  = t - 6'd10;
         ns = 1'b0;
      end
      return {ns, t[4:0]};
   endfunction

   always_comb begin
      w_state    = r_state;
      w_card_req = r_card_req;
      w_shuf     = 1'b0;
      w_ph       = r_ph;
      w_dh       = r_dh;
      w_ps       = r_ps;
      w_ds       = r_ds;
      w_disp     = r_disp;
      w_reshuf   = r_reshuf;
      w_cnt      = r_cnt;
      w_acc      = r_card_req & card_valid;
      w_pc       = add_card(r_ph, r_ps, card_rank);
      w_dc       = add_card(r_dh, r_ds, card_rank);

      if (deck_low && (r_state == S_IDLE || r_state == S_END))
         w_reshuf = 1'b1;

      unique case (r_state)
         S_IDLE: begin
            if (btn_deal) begin
               if (r_reshuf) begin
                  w_state = S_LOAD;
                  w_shuf  = 1'b1;
               end else begin
                  w_state    = S_DEAL;
                  w_card_req = 1'b1;
                  w_ph       = 5'd0;
                  w_dh       = 5'd0;
                  w_ps       = 1'b0;
                  w_ds       = 1'b0;
                  w_cnt      = 3'd0;
               end
            end
         end
         S_LOAD: begin
            if (shuffle_done) begin
               w_state  = S_IDLE;
               w_reshuf = 1'b0;
            end
         end
         S_DEAL: begin
            if (r_cnt == 3'd4) begin
               if (r_ph == L_BJ && r_dh == L_BJ) begin
                  w_state = S_END;
                  w_disp  = D_TIE;
               end else if (r_ph == L_BJ) begin
                  w_state = S_END;
                  w_disp  = D_BJ;
               end else begin
                  w_state = S_PLAYER;
               end
            end else if (w_acc) begin
               // Even draws go to the player, odd draws to the dealer.
               w_card_req = 1'b0;
               w_cnt      = r_cnt + 3'd1;
               if (!r_cnt[0]) {w_ps, w_ph} = w_pc;
               else           {w_ds, w_dh} = w_dc;
            end else begin
               w_card_req = 1'b1;
            end
         end
         S_PLAYER: begin
            if (r_ph > L_BJ) begin
               w_state = S_END;
               w_disp  = D_LOSE;
            end else if (r_ph == L_BJ) begin
               w_state = S_DEALER;
            end else if (r_card_req) begin
               if (w_acc) begin
                  w_card_req  = 1'b0;
                  {w_ps, w_ph} = w_pc;
               end
            end else if (btn_stand) begin
               w_state = S_DEALER;
            end else if (btn_hit) begin
               w_card_req = 1'b1;
            end
         end
         S_DEALER: begin
            if (r_card_req) begin
               if (w_acc) begin
                  w_card_req  = 1'b0;
                  {w_ds, w_dh} = w_dc;
               end
            end else if (r_dh < L_STAND) begin
               w_card_req = 1'b1;
            end else begin
               w_state = S_END;
               if (r_dh > L_BJ)       w_disp = D_WIN;
               else if (r_ph > r_dh)  w_disp = D_WIN;
               else if (r_ph == r_dh) w_disp = D_TIE;
               else                   w_disp = D_LOSE;
            end
         end
         S_END: begin
            if (btn_deal) w_state = S_IDLE;
         end
         default: begin
            w_state    = S_IDLE;
            w_card_req = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_card_req <= 1'b0;
         r_shuf     <= 1'b0;
         r_ph       <= 5'd0;
         r_dh       <= 5'd0;
         r_ps       <= 1'b0;
         r_ds       <= 1'b0;
         r_disp     <= D_LOSE;
         r_reshuf   <= 1'b1;
         r_cnt      <= 3'd0;
      end else begin
         r_state    <= w_state;
         r_card_req <= w_card_req;
         r_shuf     <= w_shuf;
         r_ph       <= w_ph;
         r_dh       <= w_dh;
         r_ps       <= w_ps;
         r_ds       <= w_ds;
         r_disp     <= w_disp;
         r_reshuf   <= w_reshuf;
         r_cnt      <= w_cnt;
      end
   end

   assign card_req           = r_card_req;
   assign shuffle_start      = r_shuf;
   assign state              = r_state;
   assign player_hand        = r_ph;
   assign dealer_hand        = r_dh;
   assign display_state      = r_disp;
   assign reset_to_reshuffle = r_reshuf;

endmodule

// File: tb/tb_blackjack_game_fsm.sv
// Directed bench for blackjack_game_fsm: reload, blackjack, bust,
// dealer draw, soft ace, stalled handshake and mid-round reset.
module tb_blackjack_game_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_deal, btn_hit, btn_stand;
   logic       card_valid;
   logic [3:0] card_rank;
   logic       deck_low, shuffle_done;
   logic       card_req, shuffle_start;
   logic [2:0] state;
   logic [4:0] player_hand, dealer_hand;
   logic [1:0] display_state;
   logic       reset_to_reshuffle;

   int checks = 0;
   int errors = 0;

   blackjack_game_fsm #(.DEALER_STAND(17), .BJ_TOTAL(21)) dut (
      .clk                (clk),
      .rst                (rst),
      .btn_deal           (btn_deal),
      .btn_hit            (btn_hit),
      .btn_stand          (btn_stand),
      .card_valid         (card_valid),
      .card_rank          (card_rank),
      .deck_low           (deck_low),
      .shuffle_done       (shuffle_done),
      .card_req           (card_req),
      .shuffle_start      (shuffle_start),
      .state              (state),
      .player_hand        (player_hand),
      .dealer_hand        (dealer_hand),
      .display_state      (display_state),
      .reset_to_reshuffle (reset_to_reshuffle)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic give_card(input logic [3:0] r);
      int n;
      n = 0;
      while (card_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("card_req_seen", 32'(card_req), 1);
      card_valid = 1'b1;
      card_rank  = r;
      step();
      card_valid = 1'b0;
      card_rank  = 4'd0;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s);
      int n;
      n = 0;
      while (state !== s && n < 20) begin
         step();
         n++;
      end
      chk(tag, 32'(state), 32'(s));
   endtask

   task automatic pulse_deal();
      btn_deal = 1'b1;
      step();
      btn_deal = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      btn_deal = 0; btn_hit = 0; btn_stand = 0;
      card_valid = 0; card_rank = 0;
      deck_low = 0; shuffle_done = 0;
      step(); step();
      chk("rst_state", 32'(state), 0);
      chk("rst_phand", 32'(player_hand), 0);
      chk("rst_dhand", 32'(dealer_hand), 0);
      chk("rst_disp", 32'(display_state), 0);
      chk("rst_req", 32'(card_req), 0);
      chk("rst_shuf", 32'(shuffle_start), 0);
      chk("rst_reshuf", 32'(reset_to_reshuffle), 1);
      rst = 1'b0;
      step();

      // Power-up reload
      pulse_deal();
      chk("load_state", 32'(state), 5);
      chk("shuf_pulse", 32'(shuffle_start), 1);
      btn_deal = 1'b1;
      step();
      btn_deal = 1'b0;
      chk("shuf_pulse_end", 32'(shuffle_start), 0);
      chk("load_ignores_deal", 32'(state), 5);
      shuffle_done = 1'b1;
      step();
      shuffle_done = 1'b0;
      chk("load_done_state", 32'(state), 0);
      chk("load_done_reshuf", 32'(reset_to_reshuffle), 0);

      // Player blackjack: 10,9,A,7
      pulse_deal();
      chk("deal_state", 32'(state), 1);
      chk("deal_req", 32'(card_req), 1);
      give_card(4'd10);
      chk("req_low_after_acc", 32'(card_req), 0);
      chk("p_first_card", 32'(player_hand), 10);
      give_card(4'd9);
      give_card(4'd1);
      give_card(4'd7);
      wait_state("bj_state", 3'd4);
      chk("bj_disp", 32'(display_state), 3);
      chk("bj_phand", 32'(player_hand), 21);
      chk("bj_dhand", 32'(dealer_hand), 16);

      // Player bust on face card
      pulse_deal();
      chk("end_to_idle", 32'(state), 0);
      chk("hands_hold_idle", 32'(player_hand), 21);
      pulse_deal();
      give_card(4'd10);
      give_card(4'd10);
      give_card(4'd6);
      give_card(4'd7);
      wait_state("bust_pturn", 3'd2);
      btn_hit = 1'b1;
      step();
      btn_hit = 1'b0;
      give_card(4'd13);
      chk("bust_phand", 32'(player_hand), 26);
      step();
      chk("bust_state", 32'(state), 4);
      chk("bust_disp", 32'(display_state), 0);
      step(); step(); step();
      chk("bust_no_draw", 32'(card_req), 0);
      chk("bust_dhand", 32'(dealer_hand), 17);

      // Stand, dealer draws from 16 to 26
      pulse_deal();
      pulse_deal();
      give_card(4'd5);
      give_card(4'd10);
      give_card(4'd6);
      give_card(4'd6);
      wait_state("stand_pturn", 3'd2);
      btn_stand = 1'b1;
      step();
      btn_stand = 1'b0;
      chk("stand_state", 32'(state), 3);
      give_card(4'd10);
      chk("dealer_bust_hand", 32'(dealer_hand), 26);
      wait_state("dealer_bust_end", 3'd4);
      chk("dealer_bust_disp", 32'(display_state), 2);
      chk("dealer_bust_phand", 32'(player_hand), 11);

      // Deck low while in END_GAME forces reload
      deck_low = 1'b1;
      step();
      deck_low = 1'b0;
      chk("deck_low_flag", 32'(reset_to_reshuffle), 1);
      pulse_deal();
      pulse_deal();
      chk("reload_state", 32'(state), 5);
      chk("reload_pulse", 32'(shuffle_start), 1);
      shuffle_done = 1'b1;
      step();
      shuffle_done = 1'b0;
      chk("reload_done", 32'(reset_to_reshuffle), 0);

      // Soft aces A,10,A,7 then stalled hit, then 9 -> 21
      pulse_deal();
      give_card(4'd1);
      give_card(4'd10);
      give_card(4'd1);
      give_card(4'd7);
      chk("soft_phand", 32'(player_hand), 12);
      chk("soft_dhand", 32'(dealer_hand), 17);
      wait_state("soft_pturn", 3'd2);
      btn_hit = 1'b1;
      step();
      btn_hit = 1'b0;
      step();
      btn_stand = 1'b1;
      step();
      btn_stand = 1'b0;
      step(); step(); step();
      chk("stall_req", 32'(card_req), 1);
      chk("stall_phand", 32'(player_hand), 12);
      chk("stall_state", 32'(state), 2);
      give_card(4'd9);
      chk("soft21_phand", 32'(player_hand), 21);
      step();
      chk("auto_dealer", 32'(state), 3);
      wait_state("soft_end", 3'd4);
      chk("soft_disp", 32'(display_state), 2);

      // Hit+stand together, then reset during a dealer draw
      pulse_deal();
      pulse_deal();
      give_card(4'd10);
      give_card(4'd6);
      give_card(4'd10);
      give_card(4'd5);
      wait_state("hs_pturn", 3'd2);
      btn_hit = 1'b1;
      btn_stand = 1'b1;
      step();
      btn_hit = 1'b0;
      btn_stand = 1'b0;
      chk("hs_state", 32'(state), 3);
      chk("hs_no_req", 32'(card_req), 0);
      chk("hs_phand", 32'(player_hand), 20);
      step();
      chk("dealer_req", 32'(card_req), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_req", 32'(card_req), 0);
      chk("mid_rst_state", 32'(state), 0);
      chk("mid_rst_phand", 32'(player_hand), 0);
      chk("mid_rst_dhand", 32'(dealer_hand), 0);
      chk("mid_rst_reshuf", 32'(reset_to_reshuffle), 1);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_state", 32'(state), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
